// File: rtl/mc_pkg.sv
// ============================================================================
// Module : mc_pkg
// Brief  : State, opcode and datapath-select encodings for multicycle_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_nextstate.sv
// ============================================================================
// Module : mc_nextstate
// Brief  : Combinational next-state logic of the multicycle controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_nextstate
    import mc_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output logic [3:0] next_o
);

    state_t w_state;
    state_t w_next;

    assign w_state = state_t'(state_i);
    assign next_o  = w_next;

    always_comb begin
        w_next = S_FETCH;
        case (w_state)
            S_FETCH:    w_next = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_next = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWR:    w_next = mem_ready_i ? S_FETCH : S_MEMWR;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ADDIEXEC: w_next = S_ADDIWB;
            default:    w_next = S_FETCH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Moore-style control FSM for a multicycle MIPS-subset datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       pcen,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] w_next;

    logic w_pcwrite;
    logic w_branch;
    logic w_irwrite;
    logic w_memwrite;
    logic w_regwrite;
    logic w_done;
    logic w_illegal;

    mc_nextstate u_nextstate (
        .state_i     (state_q),
        .op_i        (op),
        .mem_ready_i (mem_ready),
        .next_o      (w_next)
    );

    assign state_d = state_t'(w_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ALUSRCB_REG;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = ALUSRCB_FOUR;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb   = ALUSRCB_BRIMM;
                w_illegal = !is_legal_op(op);
                w_done    = w_illegal;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_MEMWR: begin
                // The store strobe is held across wait states; it only
                // completes (and ends the instruction) once memory is ready.
                iord       = 1'b1;
                w_memwrite = 1'b1;
                w_done     = mem_ready;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = PCSRC_ALUOUT;
                w_branch = 1'b1;
                w_done   = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = PCSRC_JUMP;
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Side-effecting strobes are suppressed during reset, whatever the state.
    assign irwrite    = w_irwrite  & ~reset;
    assign memwrite   = w_memwrite & ~reset;
    assign regwrite   = w_regwrite & ~reset;
    assign pcen       = (w_pcwrite | (w_branch & zero)) & ~reset;
    assign instr_done = w_done     & ~reset;
    assign illegal_op = w_illegal  & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Directed vector table plus latency sequences for multicycle_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       pcen, instr_done, illegal_op;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .pcen       (pcen),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    // {iord,memwrite,irwrite,regwrite}_{regdst,memtoreg,alusrca}_{alusrcb}_{pcsrc}_{aluop}_{pcen,done,illegal}
    logic [15:0] got;
    assign got = {iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                  alusrcb, pcsrc, aluop, pcen, instr_done, illegal_op};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    localparam logic [15:0] E_RST_FETCH = 16'b0000_000_01_00_00_000;
    localparam logic [15:0] E_FETCH1    = 16'b0010_000_01_00_00_100;
    localparam logic [15:0] E_FETCH0    = 16'b0000_000_01_00_00_000;
    localparam logic [15:0] E_DECODE    = 16'b0000_000_11_00_00_000;
    localparam logic [15:0] E_DEC_BAD   = 16'b0000_000_11_00_00_011;
    localparam logic [15:0] E_MEMADR    = 16'b0000_001_10_00_00_000;
    localparam logic [15:0] E_MEMRD     = 16'b1000_000_00_00_00_000;
    localparam logic [15:0] E_MEMWB     = 16'b0001_010_00_00_00_010;
    localparam logic [15:0] E_MEMWR1    = 16'b1100_000_00_00_00_010;
    localparam logic [15:0] E_MEMWR0    = 16'b1100_000_00_00_00_000;
    localparam logic [15:0] E_MEMWR_RST = 16'b1000_000_00_00_00_000;
    localparam logic [15:0] E_EXECUTE   = 16'b0000_001_00_00_10_000;
    localparam logic [15:0] E_ALUWB     = 16'b0001_100_00_00_00_010;
    localparam logic [15:0] E_BR_Z1     = 16'b0000_001_00_01_01_110;
    localparam logic [15:0] E_BR_Z0     = 16'b0000_001_00_01_01_010;
    localparam logic [15:0] E_ADDIEXEC  = 16'b0000_001_10_00_00_000;
    localparam logic [15:0] E_ADDIWB    = 16'b0001_000_00_00_00_010;
    localparam logic [15:0] E_JUMP      = 16'b0000_000_00_10_00_110;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        mr;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [5:0] o, input logic z,
                       input logic m, input logic [15:0] e, input string n);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.mr = m; v.exp = e; v.name = n;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs are applied just after a rising edge; outputs sampled at the falling edge.
    task automatic apply(input logic r, input logic [5:0] o, input logic z, input logic m);
        reset = r; op = o; zero = z; mem_ready = m;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, RT, 1'b0, 1'b0); advance();
        apply(1'b1, RT, 1'b0, 1'b0); advance();
    endtask

    logic [15:0] m_done, m_rw, m_m2r, m_rd;
    int          n_mw;

    initial begin
        reset = 1'b1; op = RT; zero = 1'b0; mem_ready = 1'b0;

        add(1, LW,  1, 1, E_RST_FETCH, "reset_fetch");
        add(0, LW,  0, 1, E_FETCH1,    "lw_fetch");
        add(0, LW,  0, 1, E_DECODE,    "lw_decode");
        add(0, LW,  0, 1, E_MEMADR,    "lw_memadr");
        add(0, LW,  0, 1, E_MEMRD,     "lw_memrd");
        add(0, LW,  0, 1, E_MEMWB,     "lw_memwb");
        add(0, SW,  0, 0, E_FETCH0,    "sw_fetch_wait");
        add(0, SW,  0, 1, E_FETCH1,    "sw_fetch");
        add(0, SW,  0, 1, E_DECODE,    "sw_decode");
        add(0, SW,  0, 1, E_MEMADR,    "sw_memadr");
        add(0, SW,  0, 0, E_MEMWR0,    "sw_memwr_wait1");
        add(0, SW,  1, 0, E_MEMWR0,    "sw_memwr_wait2");
        add(0, SW,  0, 1, E_MEMWR1,    "sw_memwr_done");
        add(0, BEQ, 1, 1, E_FETCH1,    "beq1_fetch");
        add(0, BEQ, 1, 1, E_DECODE,    "beq1_decode");
        add(0, BEQ, 1, 1, E_BR_Z1,     "beq1_branch_taken");
        add(0, BEQ, 0, 1, E_FETCH1,    "beq0_fetch");
        add(0, BEQ, 0, 1, E_DECODE,    "beq0_decode");
        add(0, BEQ, 0, 1, E_BR_Z0,     "beq0_branch_not_taken");
        add(0, BAD, 0, 1, E_FETCH1,    "bad_fetch");
        add(0, BAD, 0, 1, E_DEC_BAD,   "bad_decode");
        add(0, RT,  0, 1, E_FETCH1,    "r_fetch");
        add(0, RT,  0, 1, E_DECODE,    "r_decode");
        add(0, LW,  1, 1, E_EXECUTE,   "r_execute_op_ignored");
        add(0, BEQ, 1, 1, E_ALUWB,     "r_aluwb_op_ignored");
        add(0, ADDI,0, 1, E_FETCH1,    "addi_fetch");
        add(0, ADDI,0, 1, E_DECODE,    "addi_decode");
        add(0, ADDI,1, 1, E_ADDIEXEC,  "addi_exec");
        add(0, ADDI,0, 1, E_ADDIWB,    "addi_wb");
        add(0, JMP, 0, 1, E_FETCH1,    "j_fetch");
        add(0, JMP, 0, 1, E_DECODE,    "j_decode");
        add(0, JMP, 0, 1, E_JUMP,      "j_jump");
        add(0, LW,  0, 1, E_FETCH1,    "lw2_fetch");
        add(0, LW,  0, 1, E_DECODE,    "lw2_decode");
        add(0, LW,  0, 1, E_MEMADR,    "lw2_memadr");
        add(0, LW,  0, 0, E_MEMRD,     "lw2_memrd_wait");
        add(0, LW,  0, 1, E_MEMRD,     "lw2_memrd");
        add(0, LW,  0, 0, E_MEMWB,     "lw2_memwb");
        add(0, SW,  0, 1, E_FETCH1,    "swr_fetch");
        add(0, SW,  0, 1, E_DECODE,    "swr_decode");
        add(0, SW,  0, 1, E_MEMADR,    "swr_memadr");
        add(0, SW,  0, 0, E_MEMWR0,    "swr_memwr_wait");
        add(1, SW,  0, 0, E_MEMWR_RST, "swr_reset_in_memwr");
        add(0, SW,  0, 0, E_FETCH0,    "swr_after_reset_fetch");

        do_reset();
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].op, tbl[i].zero, tbl[i].mr);
            check(tbl[i].name, 32'(got), 32'(tbl[i].exp));
            advance();
        end

        // lw, zero wait states: five cycles, write-back only in the last.
        do_reset();
        m_done = '0; m_rw = '0; m_m2r = '0;
        for (int c = 1; c <= 5; c++) begin
            apply(1'b0, LW, 1'b0, 1'b1);
            m_done[c] = instr_done; m_rw[c] = regwrite; m_m2r[c] = memtoreg;
            advance();
        end
        check("lw_done_cycles",     32'(m_done), 32'h0020);
        check("lw_regwrite_cycles", 32'(m_rw),   32'h0020);
        check("lw_memtoreg_cycles", 32'(m_m2r),  32'h0020);
        apply(1'b0, LW, 1'b0, 1'b1);
        check("lw_back_to_fetch", 32'(got), 32'(E_FETCH1));
        advance();

        // sw with two wait cycles in MEMWR: six cycles total.
        do_reset();
        m_done = '0; n_mw = 0;
        for (int c = 1; c <= 8; c++) begin
            apply(1'b0, SW, 1'b0, (c == 4 || c == 5) ? 1'b0 : 1'b1);
            m_done[c] = instr_done;
            if (memwrite) n_mw++;
            advance();
        end
        check("sw_done_cycles",   32'(m_done), 32'h0040);
        check("sw_memwrite_count", 32'(n_mw),  32'd3);

        // Back-to-back R-type, addi, j.
        do_reset();
        m_done = '0; m_rd = '0;
        for (int c = 1; c <= 11; c++) begin
            apply(1'b0, (c <= 4) ? RT : (c <= 8) ? ADDI : JMP, 1'b0, 1'b1);
            m_done[c] = instr_done; m_rd[c] = regdst;
            advance();
        end
        check("seq_done_cycles",   32'(m_done), 32'h0910);
        check("seq_regdst_cycles", 32'(m_rd),   32'h0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings are fixed constants in mc_pkg.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  opcode field of the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory access completes this cycle.
REQ-007 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 memwrite, irwrite, regwrite  out  1 each  write strobes for memory, IR and register file.
REQ-009 regdst, memtoreg, alusrca  out  1 each  datapath mux selects.
REQ-010 alusrcb, pcsrc, aluop  out  2 each  datapath mux selects and ALU-decoder class (00 add, 01 sub, 10 funct).
REQ-011 pcen  out  1  PC register enable.
REQ-012 instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-013 illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-014 The FSM SHALL use 4-bit states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-015 Outputs SHALL be Moore functions of state, except for the mem_ready qualification in REQ-016 and REQ-019 and the pcen term in REQ-023; unlisted outputs SHALL be 0.
REQ-016 FETCH: alusrcb=01, irwrite=mem_ready, pcwrite=mem_ready. Hold while mem_ready=0; go to DECODE when mem_ready=1.
REQ-017 DECODE: alusrcb=11. Next state by op:
- 100011 or 101011 -> MEMADR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 -> ADDIEXEC
- 000010 -> JUMP
- any other value -> FETCH, with illegal_op=1.
REQ-018 MEMADR: alusrca=1, alusrcb=10. Next: MEMRD if op=100011, otherwise MEMWR.
REQ-019 MEMRD: iord=1; hold until mem_ready, then MEMWB. MEMWR: iord=1, memwrite=1; hold until mem_ready, then FETCH.
REQ-020 MEMWB: memtoreg=1, regwrite=1, then FETCH. ALUWB: regdst=1, regwrite=1, then FETCH. ADDIWB: regwrite=1, then FETCH.
REQ-021 EXECUTE: alusrca=1, aluop=10, then ALUWB. ADDIEXEC: alusrca=1, alusrcb=10, then ADDIWB.
REQ-022 BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1, then FETCH. JUMP: pcsrc=10, pcwrite=1, then FETCH.
REQ-023 pcen SHALL equal pcwrite OR (branch AND zero), where pcwrite and branch are internal signals.
REQ-024 instr_done SHALL be 1 in MEMWB, MEMWR (only with mem_ready=1), ALUWB, ADDIWB, BRANCH and JUMP, and in DECODE on an illegal opcode.
REQ-025 Base instruction latencies with zero wait states:
- lw: 5 cycles
- sw: 4 cycles
- R-type: 4 cycles
- addi: 4 cycles
- beq: 3 cycles
- j: 3 cycles
REQ-026 Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle; write strobes SHALL NOT repeat during a wait.
REQ-027 op SHALL be sampled only in DECODE and MEMADR; op changes in other states SHALL have no effect.

Reset
REQ-028 reset=1 at a clock edge SHALL force FETCH in any state, including a wait state or a write state.
REQ-029 While reset=1, regwrite, memwrite, irwrite, pcen, instr_done and illegal_op SHALL be 0.

Structure
REQ-030 Package mc_pkg SHALL hold the state enum, the opcode constants and the alusrcb, pcsrc and aluop encodings.
REQ-031 Next-state logic SHALL be in one sub-module, mc_nextstate (combinational: state, op, mem_ready -> next state); the state register and output decode SHALL stay in the top.

Verification
REQ-032 Reset, then lw (op=100011) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; instr_done pulses in cycle 5.
REQ-033 sw with mem_ready=0 for 2 cycles in MEMWR -> memwrite=1 for 3 cycles; instr_done once; total 6 cycles.
REQ-034 beq (op=000100) with zero=1 -> pcen=1 in FETCH and in BRANCH; repeat with zero=0 -> pcen=0 in BRANCH.
REQ-035 op=111111 in DECODE -> illegal_op=1 and instr_done=1 for one cycle; next state FETCH; no register or memory writes.
REQ-036 reset asserted in MEMWR while mem_ready=0 -> memwrite=0 in the next cycle; state FETCH.
REQ-037 Back-to-back R-type, addi, j with mem_ready=1 -> instr_done at cycles 4, 8 and 11; regdst=1 only in the R-type write-back cycle.
